// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: request/address phase plus a data-return phase.
// master drives the request side, slave answers with handshakes and read data.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the instruction (0) and data (1) ports.
// One transaction in flight; the grant is held from request until data_ok.
module sram_like_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  sram_like_arbiter_if.slave          inst,
  sram_like_arbiter_if.slave          data,
  sram_like_arbiter_if.master         mem
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   last_owner_reg, last_owner_next;

  logic        port_req     [2];
  logic        port_wr      [2];
  logic [1:0]  port_size    [2];
  logic [31:0] port_addr    [2];
  logic [31:0] port_wdata   [2];
  logic        port_addr_ok [2];
  logic        port_data_ok [2];

  logic route_addr_ok;
  logic route_data_ok;
  logic sel_req;

  assign port_req[0]   = inst.req;
  assign port_wr[0]    = inst.wr;
  assign port_size[0]  = inst.size;
  assign port_addr[0]  = inst.addr;
  assign port_wdata[0] = inst.wdata;
  assign port_req[1]   = data.req;
  assign port_wr[1]    = data.wr;
  assign port_size[1]  = data.size;
  assign port_addr[1]  = data.addr;
  assign port_wdata[1] = data.wdata;

  // Handshakes only ever reach the current owner.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign port_addr_ok[gi] = route_addr_ok && (owner_reg == 1'(gi));
      assign port_data_ok[gi] = route_data_ok && (owner_reg == 1'(gi));
    end
  endgenerate

  assign inst.addr_ok = port_addr_ok[0];
  assign inst.data_ok = port_data_ok[0];
  assign data.addr_ok = port_addr_ok[1];
  assign data.data_ok = port_data_ok[1];
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  assign sel_req = port_req[owner_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    mem.req         = 1'b0;
    mem.wr          = 1'b0;
    mem.size        = 2'd0;
    mem.addr        = 32'd0;
    mem.wdata       = 32'd0;
    route_addr_ok   = 1'b0;
    route_data_ok   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (port_req[0] || port_req[1]) begin
          state_next = ADDR;
          if (port_req[0] && port_req[1])
            owner_next = DATA_PRIORITY ? 1'b1 : ~last_owner_reg;
          else
            owner_next = port_req[1];
        end
      end
      ADDR: begin
        // If the owner drops req here, mem.req follows and we simply wait.
        mem.req   = sel_req;
        mem.wr    = port_wr[owner_reg];
        mem.size  = port_size[owner_reg];
        mem.addr  = port_addr[owner_reg];
        mem.wdata = port_wdata[owner_reg];
        if (sel_req && mem.addr_ok) begin
          route_addr_ok   = 1'b1;
          last_owner_next = owner_reg;
          if (mem.data_ok) begin
            route_data_ok = 1'b1;
            state_next    = IDLE;
          end else begin
            state_next    = DATA;
          end
        end
      end
      DATA: begin
        route_data_ok = mem.data_ok;
        if (mem.data_ok)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: one arbiter with data priority, one round-robin, memory side driven by hand.
module tb_sram_like_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sram_like_arbiter_if i1 ();
  sram_like_arbiter_if d1 ();
  sram_like_arbiter_if m1 ();
  sram_like_arbiter_if i0 ();
  sram_like_arbiter_if d0 ();
  sram_like_arbiter_if m0 ();

  sram_like_arbiter #(.DATA_PRIORITY(1'b1)) dut_p1 (
    .clk(clk), .rst(rst), .inst(i1), .data(d1), .mem(m1)
  );
  sram_like_arbiter #(.DATA_PRIORITY(1'b0)) dut_p0 (
    .clk(clk), .rst(rst), .inst(i0), .data(d0), .mem(m0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    i1.req = 0; i1.wr = 0; i1.size = 2'd2; i1.addr = 0; i1.wdata = 0;
    d1.req = 0; d1.wr = 0; d1.size = 2'd2; d1.addr = 0; d1.wdata = 0;
    m1.addr_ok = 0; m1.data_ok = 0; m1.rdata = 0;
    i0.req = 0; i0.wr = 0; i0.size = 2'd2; i0.addr = 0; i0.wdata = 0;
    d0.req = 0; d0.wr = 0; d0.size = 2'd2; d0.addr = 0; d0.wdata = 0;
    m0.addr_ok = 0; m0.data_ok = 0; m0.rdata = 0;
    tick(); tick();
    #1;
    chk("rst_mem_req", 32'(m1.req), 32'd0);
    chk("rst_inst_addr_ok", 32'(i1.addr_ok), 32'd0);
    chk("rst_data_data_ok", 32'(d1.data_ok), 32'd0);
    rst = 1'b1;
    tick();

    // Instruction-only read
    i1.req = 1; i1.addr = 32'hBFC00000;
    #1 chk("t1_idle_mem_req", 32'(m1.req), 32'd0);
    tick();
    chk("t1_mem_req", 32'(m1.req), 32'd1);
    chk("t1_mem_addr", m1.addr, 32'hBFC00000);
    chk("t1_addr_ok_wait", 32'(i1.addr_ok), 32'd0);
    m1.addr_ok = 1;
    #1 chk("t1_inst_addr_ok", 32'(i1.addr_ok), 32'd1);
    chk("t1_data_addr_ok", 32'(d1.addr_ok), 32'd0);
    tick();
    i1.req = 0; m1.addr_ok = 0; m1.data_ok = 1; m1.rdata = 32'h3C010001;
    #1 chk("t1_inst_data_ok", 32'(i1.data_ok), 32'd1);
    chk("t1_inst_rdata", i1.rdata, 32'h3C010001);
    chk("t1_inst_addr_ok_low", 32'(i1.addr_ok), 32'd0);
    chk("t1_data_data_ok", 32'(d1.data_ok), 32'd0);
    chk("t1_data_mem_req", 32'(m1.req), 32'd0);
    tick();
    m1.data_ok = 0;
    #1 chk("t1_done_data_ok", 32'(i1.data_ok), 32'd0);

    // Simultaneous requests, data priority
    i1.req = 1; i1.addr = 32'hBFC00004;
    d1.req = 1; d1.wr = 1; d1.size = 2'd2; d1.addr = 32'h80001000; d1.wdata = 32'hDEADBEEF;
    #1 chk("t2_idle_mem_req", 32'(m1.req), 32'd0);
    tick();
    chk("t2_mem_req", 32'(m1.req), 32'd1);
    chk("t2_mem_wr", 32'(m1.wr), 32'd1);
    chk("t2_mem_size", 32'(m1.size), 32'd2);
    chk("t2_mem_addr", m1.addr, 32'h80001000);
    chk("t2_mem_wdata", m1.wdata, 32'hDEADBEEF);
    m1.addr_ok = 1;
    #1 chk("t2_data_addr_ok", 32'(d1.addr_ok), 32'd1);
    chk("t2_inst_addr_ok", 32'(i1.addr_ok), 32'd0);
    tick();
    d1.req = 0; d1.wr = 0; m1.addr_ok = 0; m1.data_ok = 1;
    #1 chk("t2_data_data_ok", 32'(d1.data_ok), 32'd1);
    chk("t2_inst_data_ok", 32'(i1.data_ok), 32'd0);
    tick();
    m1.data_ok = 0;
    #1 chk("t2_gap_mem_req", 32'(m1.req), 32'd0);
    tick();
    chk("t2_inst_mem_req", 32'(m1.req), 32'd1);
    chk("t2_inst_mem_addr", m1.addr, 32'hBFC00004);
    chk("t2_inst_mem_wr", 32'(m1.wr), 32'd0);
    m1.addr_ok = 1; m1.data_ok = 1;
    #1 chk("t2_inst_addr_ok2", 32'(i1.addr_ok), 32'd1);
    chk("t2_inst_data_ok2", 32'(i1.data_ok), 32'd1);
    tick();
    i1.req = 0; m1.addr_ok = 0; m1.data_ok = 0;
    #1 chk("t2_end_mem_req", 32'(m1.req), 32'd0);

    // addr_ok and data_ok in the same cycle
    d1.req = 1; d1.wr = 0; d1.addr = 32'h80000010;
    tick();
    m1.addr_ok = 1; m1.data_ok = 1; m1.rdata = 32'h12345678;
    #1 chk("t4_data_addr_ok", 32'(d1.addr_ok), 32'd1);
    chk("t4_data_data_ok", 32'(d1.data_ok), 32'd1);
    chk("t4_data_rdata", d1.rdata, 32'h12345678);
    chk("t4_inst_data_ok", 32'(i1.data_ok), 32'd0);
    tick();
    m1.addr_ok = 0; m1.data_ok = 0;
    #1 chk("t4_idle_mem_req", 32'(m1.req), 32'd0);
    d1.req = 0;
    tick();

    // Spurious responses while idle
    m1.addr_ok = 1; m1.data_ok = 1;
    #1 chk("t6_inst_data_ok", 32'(i1.data_ok), 32'd0);
    chk("t6_data_data_ok", 32'(d1.data_ok), 32'd0);
    chk("t6_inst_addr_ok", 32'(i1.addr_ok), 32'd0);
    tick();
    m1.addr_ok = 0; m1.data_ok = 0; i1.req = 1; i1.addr = 32'hBFC00008;
    #1 chk("t6_still_idle", 32'(m1.req), 32'd0);
    tick();
    chk("t6_then_addr", 32'(m1.req), 32'd1);
    m1.addr_ok = 1;
    tick();
    i1.req = 0; m1.addr_ok = 0;

    // Reset while in DATA, stale data_ok afterwards
    m1.data_ok = 1; rst = 0;
    #1 chk("t5_rst_inst_data_ok", 32'(i1.data_ok), 32'd0);
    chk("t5_rst_mem_req", 32'(m1.req), 32'd0);
    chk("t5_rst_data_data_ok", 32'(d1.data_ok), 32'd0);
    tick();
    rst = 1;
    tick();
    chk("t5_stale_inst_data_ok", 32'(i1.data_ok), 32'd0);
    chk("t5_stale_data_data_ok", 32'(d1.data_ok), 32'd0);
    m1.data_ok = 0;

    // Round-robin: one data transaction first so the last owner is data
    d0.req = 1; d0.addr = 32'h80002000;
    tick();
    m0.addr_ok = 1; m0.data_ok = 1;
    #1 chk("t3_pre_data_ok", 32'(d0.data_ok), 32'd1);
    i0.req = 1; i0.addr = 32'hBFC00100;
    tick();
    m0.addr_ok = 0; m0.data_ok = 0;
    #1 chk("t3_pre_idle", 32'(m0.req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic exp_inst;
      exp_inst = (k % 2 == 0);
      tick();
      chk($sformatf("t3_req_%0d", k), 32'(m0.req), 32'd1);
      chk($sformatf("t3_addr_%0d", k), m0.addr, exp_inst ? 32'hBFC00100 : 32'h80002000);
      m0.addr_ok = 1; m0.data_ok = 1;
      #1 chk($sformatf("t3_inst_ok_%0d", k), 32'(i0.data_ok), 32'(exp_inst));
      chk($sformatf("t3_data_ok_%0d", k), 32'(d0.data_ok), 32'(!exp_inst));
      tick();
      m0.addr_ok = 0; m0.data_ok = 0;
      #1 chk($sformatf("t3_gap_%0d", k), 32'(m0.req), 32'd0);
    end
    i0.req = 0; d0.req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
